// File: rtl/uart_rx_frame_check.sv
// uart_rx_frame_check: UART RX frame assembler with parity/stop checking
// and saturating error counters.
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frame_start,
   input  logic                  bit_vld,
   input  logic                  sampled_bit,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic                  STP_2,
   input  logic                  cnt_clr,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  frame_done,
   output logic                  par_err,
   output logic                  stp_err,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt
);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_t;
   state_t state, state_nx;

   logic [IW-1:0]         idx;
   logic [DATA_WIDTH-1:0] shreg;
   logic [1:0]            ptyp_q;
   logic par_run, pen_q, stp2_q, perr_int, serr_int;
   logic acc, last_data, par_exp, done, perr_new, serr_new;

   // A strobe coinciding with frame_start belongs to the aborted frame and is dropped.
   assign acc       = bit_vld & ~frame_start;
   assign last_data = idx == IW'(DATA_WIDTH - 1);
   assign par_exp   = ptyp_q[1] ? ~ptyp_q[0] : par_run ^ ptyp_q[0];
   assign done      = acc & ((state == STOP1 && !stp2_q) || state == STOP2);
   assign perr_new  = pen_q & perr_int;
   assign serr_new  = ~sampled_bit | (state == STOP2 && serr_int);
   assign busy      = state != IDLE;

   always_ff @(posedge CLK or negedge RST)
      if (!RST) state <= IDLE;
      else      state <= state_nx;

   always_comb begin
      state_nx = state;
      if (frame_start) state_nx = DATA;
      else if (bit_vld)
         case (state)
            DATA:    state_nx = last_data ? (pen_q ? PARITY : STOP1) : DATA;
            PARITY:  state_nx = STOP1;
            STOP1:   state_nx = stp2_q ? STOP2 : IDLE;
            STOP2:   state_nx = IDLE;
            default: state_nx = state;
         endcase
   end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         idx        <= '0;
         shreg      <= '0;
         ptyp_q     <= '0;
         par_run    <= 1'b0;
         pen_q      <= 1'b0;
         stp2_q     <= 1'b0;
         perr_int   <= 1'b0;
         serr_int   <= 1'b0;
         P_DATA     <= '0;
         frame_done <= 1'b0;
         par_err    <= 1'b0;
         stp_err    <= 1'b0;
      end else begin
         frame_done <= done;
         if (frame_start) begin
            idx      <= '0;
            shreg    <= '0;
            par_run  <= 1'b0;
            perr_int <= 1'b0;
            serr_int <= 1'b0;
            pen_q    <= PAR_EN;
            ptyp_q   <= PAR_TYP;
            stp2_q   <= STP_2;
         end else if (acc) begin
            if (state == DATA) begin
               shreg[idx] <= sampled_bit;
               par_run    <= par_run ^ sampled_bit;
               idx        <= idx + 1'b1;
            end
            if (state == PARITY) perr_int <= sampled_bit != par_exp;
            if (state == STOP1)  serr_int <= ~sampled_bit;
         end
         if (done) begin
            P_DATA  <= shreg;
            par_err <= perr_new;
            stp_err <= serr_new;
         end
      end

   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (cnt_clr) begin
         par_err_cnt <= '0;
         stp_err_cnt <= '0;
      end else if (done) begin
         if (perr_new && par_err_cnt != CNT_MAX) par_err_cnt <= par_err_cnt + 1'b1;
         if (serr_new && stp_err_cnt != CNT_MAX) stp_err_cnt <= stp_err_cnt + 1'b1;
      end
endmodule

// File: tb/tb_uart_rx_frame_check.sv
// tb_uart_rx_frame_check: directed frames with hand-computed expectations.
module tb_uart_rx_frame_check;
   logic       CLK = 0, RST = 0, frame_start = 0, bit_vld = 0, sampled_bit = 0;
   logic       PAR_EN = 0, STP_2 = 0, cnt_clr = 0;
   logic [1:0] PAR_TYP = 0;
   logic [7:0] P_DATA;
   logic       frame_done, par_err, stp_err, busy;
   logic [1:0] par_err_cnt, stp_err_cnt;
   int n_cmp = 0, n_bad = 0, n_done = 0, d0;

   uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
      .CLK(CLK), .RST(RST), .frame_start(frame_start), .bit_vld(bit_vld),
      .sampled_bit(sampled_bit), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP_2(STP_2),
      .cnt_clr(cnt_clr), .P_DATA(P_DATA), .frame_done(frame_done), .par_err(par_err),
      .stp_err(stp_err), .busy(busy), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) n_done += int'(frame_done);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Config is scrambled right after frame_start to prove it was latched.
   task automatic start(input logic pen, input logic [1:0] ptyp, input logic stp2);
      @(negedge CLK);
      frame_start = 1; bit_vld = 1; sampled_bit = 1;
      PAR_EN = pen; PAR_TYP = ptyp; STP_2 = stp2;
      @(negedge CLK);
      frame_start = 0; bit_vld = 0;
      PAR_EN = ~pen; PAR_TYP = ~ptyp; STP_2 = ~stp2;
   endtask

   task automatic strobe(input logic b, input logic c);
      @(negedge CLK);
      bit_vld = 1; sampled_bit = b; cnt_clr = c;
      @(negedge CLK);
      bit_vld = 0; cnt_clr = 0;
   endtask

   task automatic frame(input logic [7:0] d, input logic pen, input logic [1:0] ptyp,
                        input logic stp2, input logic pbit, input logic s1, input logic s2,
                        input logic clr);
      start(pen, ptyp, stp2);
      for (int i = 0; i < 8; i++) strobe(d[i], 1'b0);
      if (pen) strobe(pbit, 1'b0);
      if (stp2) begin
         strobe(s1, 1'b0);
         chk("busy_pre", busy, 1);
         chk("nodone_pre", frame_done, 0);
         strobe(s2, clr);
      end else begin
         chk("busy_pre", busy, 1);
         strobe(s1, clr);
      end
      chk("done", frame_done, 1);
      chk("busy_post", busy, 0);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("rst_pdata", P_DATA, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_perr", par_err, 0);
      chk("rst_serr", stp_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pcnt", par_err_cnt, 0);
      chk("rst_scnt", stp_err_cnt, 0);
      RST = 1;

      frame(8'hA5, 0, 2'b00, 0, 0, 1, 1, 0);
      chk("8n1_data", P_DATA, 8'hA5);
      chk("8n1_perr", par_err, 0);
      chk("8n1_serr", stp_err, 0);
      @(negedge CLK);
      chk("done_pulse", frame_done, 0);

      frame(8'h07, 1, 2'b00, 0, 0, 1, 1, 0);
      chk("8e1_bad_perr", par_err, 1);
      chk("8e1_bad_pcnt", par_err_cnt, 1);
      frame(8'h07, 1, 2'b00, 0, 1, 1, 1, 0);
      chk("8e1_ok_perr", par_err, 0);
      chk("8e1_ok_pcnt", par_err_cnt, 1);

      frame(8'h00, 1, 2'b01, 1, 1, 1, 0, 0);
      chk("8o2_serr", stp_err, 1);
      chk("8o2_perr", par_err, 0);
      chk("8o2_scnt", stp_err_cnt, 1);
      chk("8o2_data", P_DATA, 8'h00);

      frame(8'h00, 1, 2'b10, 0, 0, 1, 1, 0);
      chk("mark_perr", par_err, 1);
      chk("mark_pcnt", par_err_cnt, 2);
      chk("mark_serr", stp_err, 0);
      frame(8'h00, 1, 2'b11, 0, 0, 1, 1, 0);
      chk("space_perr", par_err, 0);

      start(0, 2'b00, 0);
      repeat (4) strobe(1'b1, 1'b0);
      d0 = n_done;
      frame(8'h3C, 0, 2'b00, 0, 0, 1, 1, 0);
      @(negedge CLK);
      chk("abort_ndone", n_done - d0, 1);
      chk("abort_data", P_DATA, 8'h3C);

      d0 = n_done;
      repeat (3) strobe(1'b0, 1'b0);
      @(negedge CLK);
      chk("idle_ndone", n_done - d0, 0);
      chk("idle_busy", busy, 0);
      chk("idle_data", P_DATA, 8'h3C);

      @(negedge CLK); cnt_clr = 1;
      @(negedge CLK); cnt_clr = 0;
      chk("clr_pcnt", par_err_cnt, 0);
      chk("clr_scnt", stp_err_cnt, 0);

      repeat (5) frame(8'h07, 1, 2'b00, 0, 0, 1, 1, 0);
      chk("sat_pcnt", par_err_cnt, 3);
      chk("sat_perr", par_err, 1);

      start(1, 2'b00, 1);
      repeat (4) strobe(1'b1, 1'b0);
      d0 = n_done;
      @(negedge CLK); RST = 0;
      #1;
      chk("mrst_pdata", P_DATA, 0);
      chk("mrst_perr", par_err, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_pcnt", par_err_cnt, 0);
      chk("mrst_done", frame_done, 0);
      @(negedge CLK); RST = 1;
      repeat (6) strobe(1'b1, 1'b0);
      @(negedge CLK);
      chk("mrst_ndone", n_done - d0, 0);
      chk("mrst_busy2", busy, 0);

      frame(8'h3C, 0, 2'b00, 0, 0, 0, 0, 1);
      chk("clrinc_serr", stp_err, 1);
      chk("clrinc_scnt", stp_err_cnt, 0);
      chk("clrinc_data", P_DATA, 8'h3C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
